ps2_key_ctrl: RTL and testbench

Controller for the PS/2 keyboard port. It samples PS2_KBCLK/PS2_KBDAT and sequences 11-bit frame reception with start/stop/parity checking and an inactivity timeout. It folds the E0 (extended) and F0 (break) prefix bytes into single key events, which it buffers in a small FIFO. Downstream logic (LCD text writer, LED debug) pulls events through a valid/ready handshake.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_frame_rx.sv | 175 +++++++++++++++++
 rtl/ps2_key_ctrl.sv | 156 +++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
package ps2_pkg;

   // Frame receiver states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
   localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

   // One decoded key event as stored in the event FIFO
   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } ps2_evt_t;

   // Bits needed to hold a timeout count of 0..cyc
   function automatic int unsigned ps2_tout_width(input int unsigned cyc);
      return (cyc < 32'd2) ? 32'd1 : $clog2(cyc + 32'd1);
   endfunction

   // Odd parity: data bits plus parity bit must contain an odd number of ones
   function automatic logic ps2_odd_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, falling-edge
// detect, 11-bit frame FSM and inter-edge timeout.
// Optional macro: PS2_PARITY_CHECK_EN (when undefined the parity bit is ignored).
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 10000
) (
   input  logic       iCLK_50,
   input  logic       iRST,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic       en,
   output logic       frame_done,
   output logic [7:0] frame_byte,
   output logic       frame_err
);

   localparam int unsigned TW = ps2_tout_width(TIMEOUT_CYC);
   localparam logic [TW-1:0] TOUT_VAL = TW'(TIMEOUT_CYC);

   logic [1:0]    clk_sync_r;
   logic [1:0]    dat_sync_r;
   logic [7:0]    clk_hist_r;
   logic          filt_r;
   logic          filt_q_r;
   logic          fall_s;
   ps2_state_t    state_r;
   ps2_state_t    state_nxt_s;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic          par_r;
   logic [TW-1:0] tout_cnt_r;
   logic          tout_hit_s;
   logic          par_ok_s;
   logic          done_s;
   logic          err_s;
   logic          frame_done_r;
   logic          frame_err_r;

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok_s = ps2_odd_ok(shift_r, par_r);
`else
   assign par_ok_s = 1'b1;
`endif

   assign fall_s = filt_q_r & ~filt_r;

   // Synchronise pins and filter the PS/2 clock; idle lines read as high
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         clk_sync_r <= 2'b11;
         dat_sync_r <= 2'b11;
         clk_hist_r <= 8'hFF;
         filt_r     <= 1'b1;
         filt_q_r   <= 1'b1;
      end else begin
         clk_sync_r <= {clk_sync_r[0], ps2_clk};
         dat_sync_r <= {dat_sync_r[0], ps2_dat};
         clk_hist_r <= {clk_hist_r[6:0], clk_sync_r[1]};
         filt_q_r   <= filt_r;
         if (clk_hist_r == 8'hFF) begin
            filt_r <= 1'b1;
         end else if (clk_hist_r == 8'h00) begin
            filt_r <= 1'b0;
         end else begin
            filt_r <= filt_r;
         end
      end
   end

   // Next-state and frame result decode
   always_comb begin
      state_nxt_s = state_r;
      done_s      = 1'b0;
      err_s       = 1'b0;
      tout_hit_s  = (state_r != ST_IDLE) && !fall_s && (tout_cnt_r == TOUT_VAL);
      case (state_r)
         ST_IDLE: begin
            if (fall_s && en && !dat_sync_r[1]) begin
               state_nxt_s = ST_DATA;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else if (fall_s && (bit_cnt_r == 3'd7)) begin
               state_nxt_s = ST_PARITY;
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else if (fall_s) begin
               state_nxt_s = ST_STOP;
            end else begin
               state_nxt_s = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (tout_hit_s) begin
               state_nxt_s = ST_IDLE;
               err_s       = 1'b1;
            end else if (fall_s) begin
               state_nxt_s = ST_IDLE;
               if (dat_sync_r[1] && par_ok_s) begin
                  done_s = 1'b1;
               end else begin
                  err_s = 1'b1;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered frame result pulses
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         state_r      <= ST_IDLE;
         frame_done_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         frame_done_r <= done_s;
         frame_err_r  <= err_s;
      end
   end

   // Bit capture: data shifts in LSB-first, parity captured separately
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         par_r     <= 1'b0;
      end else if (fall_s && (state_r == ST_IDLE)) begin
         bit_cnt_r <= 3'd0;
      end else if (fall_s && (state_r == ST_DATA)) begin
         shift_r   <= {dat_sync_r[1], shift_r[7:1]};
         bit_cnt_r <= bit_cnt_r + 3'd1;
      end else if (fall_s && (state_r == ST_PARITY)) begin
         par_r <= dat_sync_r[1];
      end else begin
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Gap counter between clock falls while a frame is in progress
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         tout_cnt_r <= '0;
      end else if ((state_r == ST_IDLE) || fall_s) begin
         tout_cnt_r <= '0;
      end else if (tout_cnt_r != TOUT_VAL) begin
         tout_cnt_r <= tout_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         tout_cnt_r <= tout_cnt_r;
      end
   end

   assign frame_done = frame_done_r;
   assign frame_err  = frame_err_r;
   assign frame_byte = shift_r;

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard controller top: prefix decoder (E0/F0), key event FIFO with
// valid/ready output, saturating dropped-frame counter.
// Optional macro: PS2_PARITY_CHECK_EN (enables odd-parity checking in ps2_frame_rx).
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TIMEOUT_US = 200,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       iCLK_50,
   input  logic       iRST,
   input  logic       PS2_KBCLK,
   input  logic       PS2_KBDAT,
   input  logic       iEN,
   input  logic       iKEY_READY,
   output logic       oKEY_VALID,
   output logic [7:0] oKEY_CODE,
   output logic       oKEY_BREAK,
   output logic       oKEY_EXT,
   output logic [7:0] oERR_CNT,
   output logic       oOVF
);

   localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   logic          frame_done_s;
   logic          frame_err_s;
   logic [7:0]    frame_byte_s;
   logic          ext_r;
   logic          brk_r;
   logic [7:0]    err_cnt_r;
   ps2_evt_t      mem_r [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   cnt_r;
   logic [AW:0]   cnt_nxt_s;
   logic [AW-1:0] rd_nxt_s;
   ps2_evt_t      evt_s;
   ps2_evt_t      head_nxt_s;
   ps2_evt_t      head_r;
   logic          valid_r;
   logic          ovf_r;
   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          wr_s;
   logic          drop_s;

   ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .iCLK_50    (iCLK_50),
      .iRST       (iRST),
      .ps2_clk    (PS2_KBCLK),
      .ps2_dat    (PS2_KBDAT),
      .en         (iEN),
      .frame_done (frame_done_s),
      .frame_byte (frame_byte_s),
      .frame_err  (frame_err_s)
   );

   assign push_s = frame_done_s && (frame_byte_s != PS2_EXT_CODE) && (frame_byte_s != PS2_BRK_CODE);
   assign pop_s  = valid_r && iKEY_READY;
   assign full_s = (cnt_r == CNT_FULL);
   assign wr_s   = push_s && (!full_s || pop_s);
   assign drop_s = push_s && full_s && !pop_s;

   // FIFO bookkeeping and the head entry to present next cycle
   always_comb begin
      evt_s.code = frame_byte_s;
      evt_s.brk  = brk_r;
      evt_s.ext  = ext_r;
      rd_nxt_s   = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({wr_s, pop_s})
         2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
         2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
         default: cnt_nxt_s = cnt_r;
      endcase
      if (cnt_nxt_s == '0) begin
         head_nxt_s = '0;
      end else if (wr_s && (rd_nxt_s == wr_ptr_r)) begin
         head_nxt_s = evt_s;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // Prefix flags: set by E0/F0, cleared by any other good frame or a drop
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         ext_r <= 1'b0;
         brk_r <= 1'b0;
      end else if (frame_err_s) begin
         ext_r <= 1'b0;
         brk_r <= 1'b0;
      end else if (frame_done_s) begin
         if (frame_byte_s == PS2_EXT_CODE) begin
            ext_r <= 1'b1;
         end else if (frame_byte_s == PS2_BRK_CODE) begin
            brk_r <= 1'b1;
         end else begin
            ext_r <= 1'b0;
            brk_r <= 1'b0;
         end
      end else begin
         ext_r <= ext_r;
      end
   end

   // Saturating dropped-frame counter
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         err_cnt_r <= 8'd0;
      end else if (frame_err_s && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   // Event FIFO storage, pointers and registered head/valid/overflow outputs
   always_ff @(posedge iCLK_50 or posedge iRST) begin
      if (iRST) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         head_r   <= '0;
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         if (wr_s) begin
            mem_r[wr_ptr_r] <= evt_s;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r <= rd_nxt_s;
         cnt_r    <= cnt_nxt_s;
         head_r   <= head_nxt_s;
         valid_r  <= (cnt_nxt_s != '0);
         ovf_r    <= drop_s;
      end
   end

   assign oKEY_VALID = valid_r;
   assign oKEY_CODE  = head_r.code;
   assign oKEY_BREAK = head_r.brk;
   assign oKEY_EXT   = head_r.ext;
   assign oERR_CNT   = err_cnt_r;
   assign oOVF       = ovf_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed frames plus random frames
// compared against a byte-level key event model.
module tb_ps2_key_ctrl;

   localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] code;
      logic       brk;
      logic       ext;
   } ev_t;

   logic       iCLK_50 = 1'b0;
   logic       iRST = 1'b1;
   logic       kbclk = 1'b1;
   logic       kbdat = 1'b1;
   logic       en = 1'b1;
   logic       rdy = 1'b1;
   logic       oKEY_VALID;
   logic [7:0] oKEY_CODE;
   logic       oKEY_BREAK;
   logic       oKEY_EXT;
   logic [7:0] oERR_CNT;
   logic       oOVF;

   int  n_assert = 0;
   int  n_fail = 0;
   int  ovf_seen = 0;
   int  m_err = 0;
   bit  m_ext = 1'b0;
   bit  m_brk = 1'b0;
   ev_t got_q[$];
   ev_t exp_q[$];
   ev_t ovf_exp[4];

   ps2_key_ctrl #(.CLK_HZ(1_000_000), .TIMEOUT_US(200), .FIFO_DEPTH(4)) dut (
      .iCLK_50    (iCLK_50),
      .iRST       (iRST),
      .PS2_KBCLK  (kbclk),
      .PS2_KBDAT  (kbdat),
      .iEN        (en),
      .iKEY_READY (rdy),
      .oKEY_VALID (oKEY_VALID),
      .oKEY_CODE  (oKEY_CODE),
      .oKEY_BREAK (oKEY_BREAK),
      .oKEY_EXT   (oKEY_EXT),
      .oERR_CNT   (oERR_CNT),
      .oOVF       (oOVF)
   );

   always #10 iCLK_50 = ~iCLK_50;

   // Record every accepted event and every overflow pulse
   always @(negedge iCLK_50) begin
      if (!iRST) begin
         if (oKEY_VALID && rdy) got_q.push_back({oKEY_CODE, oKEY_BREAK, oKEY_EXT});
         if (oOVF) ovf_seen++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: what a keyboard byte does to the event stream and error count
   task automatic model(input logic [7:0] b, input logic par_flip, input logic stop_bit);
      bit good;
      good = stop_bit && (!par_flip || !PAR_EN);
      if (!good) begin
         if (m_err < 255) m_err++;
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         exp_q.push_back({b, m_brk, m_ext});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bit,
                             input int nbits, input bit chk_lat);
      logic [10:0] bits;
      bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge iCLK_50);
         kbdat = bits[i];
         repeat (HALF) @(negedge iCLK_50);
         kbclk = 1'b0;
         if (chk_lat && (i == 10)) begin
            repeat (12) @(posedge iCLK_50);
            #1;
            chk("lat_pre", oKEY_VALID, 1'b0);
            @(posedge iCLK_50);
            #1;
            chk("lat_valid", oKEY_VALID, 1'b1);
            repeat (HALF - 13) @(negedge iCLK_50);
         end else begin
            repeat (HALF) @(negedge iCLK_50);
         end
         kbclk = 1'b1;
      end
      @(negedge iCLK_50);
      kbdat = 1'b1;
      repeat (HALF) @(negedge iCLK_50);
   endtask

   task automatic frame(input logic [7:0] b, input logic par_flip, input logic stop_bit);
      model(b, par_flip, stop_bit);
      send_frame(b, par_flip, stop_bit, 11, 1'b0);
   endtask

   task automatic cmp_q(input string tag);
      int n;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk(tag, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_valid"}, oKEY_VALID, 1'b0);
      chk({tag, "_code"}, oKEY_CODE, 8'h00);
      chk({tag, "_brk"}, oKEY_BREAK, 1'b0);
      chk({tag, "_ext"}, oKEY_EXT, 1'b0);
      chk({tag, "_err"}, oERR_CNT, 8'h00);
      chk({tag, "_ovf"}, oOVF, 1'b0);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rp;
      logic       rs;
      int         sel;

      // Reset state
      repeat (5) @(negedge iCLK_50);
      chk_outputs_zero("reset");
      iRST = 1'b0;
      repeat (HALF) @(negedge iCLK_50);

      // Make code with event latency check
      model(8'h1C, 1'b0, 1'b1);
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
      cmp_q("make_1c");

      // Extended break: only one event for E0 F0 75
      frame(8'hE0, 1'b0, 1'b1);
      frame(8'hF0, 1'b0, 1'b1);
      chk("prefix_no_event", got_q.size(), 0);
      frame(8'h75, 1'b0, 1'b1);
      cmp_q("ext_break_75");

      // Bad parity
      frame(8'h1C, 1'b1, 1'b1);
      cmp_q("bad_parity");
      chk("bad_parity_err", oERR_CNT, PAR_EN ? 8'd1 : 8'd0);

      // Bad stop bit always counts
      frame(8'h3A, 1'b0, 1'b0);
      cmp_q("bad_stop");
      chk("bad_stop_err", oERR_CNT, m_err);

      // Timeout after start plus 4 data bits, then recovery
      send_frame(8'h1C, 1'b0, 1'b1, 5, 1'b0);
      repeat (300) @(negedge iCLK_50);
      if (m_err < 255) m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
      chk("timeout_err", oERR_CNT, m_err);
      chk("timeout_no_event", got_q.size(), 0);
      frame(8'h1C, 1'b0, 1'b1);
      cmp_q("after_timeout");

      // iEN low: start bits ignored, nothing counted
      @(posedge iCLK_50);
      #1 en = 1'b0;
      send_frame(8'h2B, 1'b0, 1'b1, 11, 1'b0);
      @(posedge iCLK_50);
      #1 en = 1'b1;
      cmp_q("en_low");
      chk("en_low_err", oERR_CNT, m_err);

      // Random frames against the reference model
      for (int k = 0; k < 12; k++) begin
         sel = $urandom_range(0, 9);
         rb  = 8'($urandom_range(0, 255));
         if (rb == 8'hE0 || rb == 8'hF0) rb = rb ^ 8'h01;
         if (sel == 0) rb = 8'hE0;
         if (sel == 1) rb = 8'hF0;
         rp = ($urandom_range(0, 3) == 0);
         rs = ($urandom_range(0, 5) != 0);
         frame(rb, rp, rs);
      end
      frame(8'h1C, 1'b0, 1'b1);
      cmp_q("random");
      chk("random_err", oERR_CNT, m_err);

      // Overflow: 5 makes with consumer stalled
      @(posedge iCLK_50);
      #1 rdy = 1'b0;
      ovf_seen = 0;
      ovf_exp[0] = {8'h16, 1'b0, 1'b0};
      ovf_exp[1] = {8'h1E, 1'b0, 1'b0};
      ovf_exp[2] = {8'h26, 1'b0, 1'b0};
      ovf_exp[3] = {8'h25, 1'b0, 1'b0};
      for (int k = 0; k < 4; k++) send_frame(ovf_exp[k].code, 1'b0, 1'b1, 11, 1'b0);
      chk("ovf_before", ovf_seen, 0);
      chk("ovf_head_hold", {oKEY_VALID, oKEY_CODE}, {1'b1, 8'h16});
      send_frame(8'h2E, 1'b0, 1'b1, 11, 1'b0);
      chk("ovf_pulses", ovf_seen, 1);
      chk("ovf_head_stable", {oKEY_VALID, oKEY_CODE}, {1'b1, 8'h16});
      got_q.delete();
      @(posedge iCLK_50);
      #1 rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge iCLK_50);
         chk("ovf_drain", {oKEY_VALID, oKEY_CODE, oKEY_BREAK, oKEY_EXT}, {1'b1, ovf_exp[k]});
      end
      @(negedge iCLK_50);
      chk("ovf_empty", oKEY_VALID, 1'b0);
      for (int k = 0; k < 4; k++) exp_q.push_back(ovf_exp[k]);
      cmp_q("ovf_order");

      // Reset mid-frame with two events queued
      @(posedge iCLK_50);
      #1 rdy = 1'b0;
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
      send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0);
      chk("pre_reset_valid", oKEY_VALID, 1'b1);
      send_frame(8'h4D, 1'b0, 1'b1, 4, 1'b0);
      @(negedge iCLK_50);
      iRST = 1'b1;
      repeat (3) @(negedge iCLK_50);
      chk_outputs_zero("mid_reset");
      iRST = 1'b0;
      got_q.delete();
      exp_q.delete();
      m_err = 0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      @(posedge iCLK_50);
      #1 rdy = 1'b1;
      repeat (HALF) @(negedge iCLK_50);
      chk("post_reset_empty", oKEY_VALID, 1'b0);
      frame(8'h1C, 1'b0, 1'b1);
      cmp_q("post_reset");
      chk("post_reset_err", oERR_CNT, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
